// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a byte producer and uart_tx.
// Pops one byte per idle transmitter period and issues a single-cycle send strobe for it.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_e_i,
    input  logic [7:0]        wr_d_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    input  logic              tx_busy_i,
    output logic              tx_e_o,
    output logic [7:0]        tx_d_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SENT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              overflow_r;
    logic              tx_e_r;
    logic [7:0]        tx_d_r;
    state_t            state_r;
    state_t            state_s;
    logic              full_s;
    logic              empty_s;
    logic              wr_accept_s;
    logic              pop_s;

    // Flags and handshake decode from the registered count
    always_comb begin
        full_s      = (count_r == CNT_DEPTH);
        empty_s     = (count_r == {(ADDR_W+1){1'b0}});
        wr_accept_s = wr_e_i && !full_s;
        pop_s       = (state_r == ST_IDLE) && !empty_s && !tx_busy_i;
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= wr_d_i;
        end
    end

    // Pointers, occupancy counter and sticky overflow flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // A write while full is dropped even if a pop frees a slot this cycle
            if (wr_e_i && full_s) begin
                overflow_r <= 1'b1;
            end
            case ({wr_accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered send strobe and data toward uart_tx
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_e_r  <= 1'b0;
            tx_d_r  <= 8'h00;
            state_r <= ST_IDLE;
        end else begin
            tx_e_r  <= pop_s;
            state_r <= state_s;
            if (pop_s) begin
                tx_d_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Issue FSM: busy is ignored in SENT because uart_tx raises it one cycle late
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_s = ST_SENT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SENT: state_s = ST_WAIT;
            ST_WAIT: begin
                if (tx_busy_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign count_o    = count_r;
    assign overflow_o = overflow_r;
    assign tx_e_o     = tx_e_r;
    assign tx_d_o     = tx_d_r;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer between a byte producer (uart_rx done_o/d_o, or a host) and uart_tx (e_i/d_i/busy_o).
- Absorbs bursts of back-to-back received bytes while the transmitter is still shifting the previous frame.
- Issues one single-cycle send strobe per stored byte, in order, whenever uart_tx is idle.
- Drops bytes that arrive while the buffer is full and reports this through a sticky flag.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
resetn  input  1  asynchronous active-low reset.
wr_e_i  input  1  write strobe; one byte accepted per high cycle (connects to uart_rx done_o).
wr_d_i  input  8  write data; sampled when wr_e_i=1.
full_o  output  1  count_o == DEPTH.
empty_o  output  1  count_o == 0.
count_o  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
overflow_o  output  1  sticky; set when a write is dropped.
tx_busy_i  input  1  uart_tx busy_o.
tx_e_o  output  1  single-cycle send strobe to uart_tx e_i.
tx_d_o  output  8  byte to uart_tx d_i; valid in the tx_e_o cycle, held until the next strobe.

Behaviour:
- Reset (resetn=0, asynchronous): rd/wr pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, tx_e_o=0, tx_d_o=8'h00, FSM=IDLE. Storage contents are don't-care.
- Reset mid-frame: all buffered bytes are discarded; any strobe in flight is cancelled.
- Storage: DEPTH x 8 circular array.
  - Pointers wrap from DEPTH-1 to 0.
  - count_o is a registered counter: +1 on accepted write, -1 on pop, unchanged on both or neither.
- Write:
  - Accepted when wr_e_i=1 and full_o=0, where full_o is the value at the start of the cycle.
  - A write while full is dropped and overflow_o is set. This holds even if a pop occurs in the same cycle: no write-through on full.
  - overflow_o is cleared only by reset.
- Pop / issue FSM (states IDLE, SENT, WAIT):
  - IDLE: if empty_o=0 and tx_busy_i=0, the next edge performs these actions together:
    - tx_d_o <= mem[rd_ptr];
    - tx_e_o <= 1;
    - rd_ptr++ and count decrement;
    - go to SENT.
    Otherwise tx_e_o <= 0 and stay in IDLE.
  - SENT: tx_e_o=1 during this cycle. Next edge: tx_e_o <= 0, go to WAIT. tx_busy_i is ignored here because uart_tx raises busy_o the cycle after sampling e_i.
  - WAIT: stay while tx_busy_i=1. When tx_busy_i=0, go to IDLE; no strobe on this edge.
- tx_e_o is never high two consecutive cycles. Minimum spacing between strobes is 3 cycles plus the frame time.
- Empty-buffer latency: wr_e_i high in cycle N, tx idle → tx_e_o high in cycle N+2.
  - Edge ending N: byte stored, empty_o falls.
  - Edge ending N+1: issue.
  - There is no bypass path.
- Simultaneous write and pop: both take effect; count_o is unchanged, and pointers advance independently.
- Write during WAIT: stored normally; it is issued after the current frame completes.
- Byte order: strictly FIFO. No byte is sent twice, and no accepted byte is lost.
- Outputs full_o and empty_o are decoded from the registered count_o, so they update the cycle after the causing edge.

Test Plan:
- Reset: hold resetn=0 for 5 cycles with wr_e_i toggling → count_o=0, empty_o=1, overflow_o=0, tx_e_o=0, tx_d_o=8'h00 throughout.
- Single byte: idle tx, wr_e_i pulse with 8'hA5 at cycle N → tx_e_o=1 with tx_d_o=8'hA5 exactly in cycle N+2 for one cycle; count_o returns to 0.
- Burst: write 8'h01..8'h05 on consecutive cycles; model uart_tx busy for 20 cycles after each strobe → strobes carry 01,02,03,04,05 in order; each strobe waits for busy to drop; count_o peaks at 4.
- Full/overflow (DEPTH=4): hold tx_busy_i=1, write 8'h10..8'h15 → count_o=4, full_o=1, overflow_o=1; release busy → only 10,11,12,13 are transmitted.
- Simultaneous: buffer holds 2 bytes, write 8'h7E in the same cycle as the issue edge → count_o stays 2; 8'h7E is sent third.
- Reset mid-operation: 3 bytes buffered with the FSM in WAIT; assert resetn=0 for 1 cycle → empty_o=1, no further strobes; a new byte 8'h3C is then sent normally.
